// File: rtl/dbg_cmd_packer.sv
// Debug-bridge command packer: host word requests -> UART command byte stream.
// Optional trailing XOR checksum byte when DBG_CMD_PACKER_CSUM_EN is defined.
module dbg_cmd_packer #(
    parameter logic [7:0]  CMD_WRITE = 8'h10,
    parameter logic [7:0]  CMD_READ  = 8'h11,
    parameter int unsigned MAX_LEN   = 252
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_len_i,
    input  logic        wdata_valid_i,
    input  logic [31:0] wdata_i,
    output logic        wdata_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_accept_i,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam logic [7:0] LP_MAX = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_ADDR,
        S_DWAIT,
        S_DATA,
        S_CSUM,
        S_END
    } state_t;

    state_t      r_state;
    logic [7:0]  r_len;
    logic [31:0] r_addr;
    logic        r_write;
    logic [7:0]  r_rem;
    logic [1:0]  r_bidx;
    logic [31:0] r_word;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;

    state_t      w_state_d;
    logic [7:0]  w_len_d;
    logic [31:0] w_addr_d;
    logic        w_write_d;
    logic [7:0]  w_rem_d;
    logic [1:0]  w_bidx_d;
    logic [31:0] w_word_d;
    logic [7:0]  w_tx_data_d;
    logic        w_tx_valid_d;

    logic        w_fire;
    logic [7:0]  w_len_cl;
    logic [1:0]  w_bidx_inc;
    logic [7:0]  w_addr_nb;
    logic [7:0]  w_word_nb;
    logic        w_req_ready;
    logic        w_wdata_ready;
    logic        w_done;

`ifdef DBG_CMD_PACKER_CSUM_EN
    logic [7:0]  r_csum;
    logic [7:0]  w_csum_d;
`endif

    assign w_fire     = r_tx_valid & tx_accept_i;
    assign w_len_cl   = (req_len_i > LP_MAX) ? LP_MAX : req_len_i;
    assign w_bidx_inc = r_bidx + 2'd1;
    // Address goes out MSB first, data words LSB first.
    assign w_addr_nb  = r_addr[{~w_bidx_inc, 3'b000} +: 8];
    assign w_word_nb  = r_word[{w_bidx_inc, 3'b000} +: 8];

    always_comb begin
        w_state_d     = r_state;
        w_len_d       = r_len;
        w_addr_d      = r_addr;
        w_write_d     = r_write;
        w_rem_d       = r_rem;
        w_bidx_d      = r_bidx;
        w_word_d      = r_word;
        w_tx_data_d   = r_tx_data;
        w_tx_valid_d  = r_tx_valid;
        w_req_ready   = 1'b0;
        w_wdata_ready = 1'b0;
        w_done        = 1'b0;
`ifdef DBG_CMD_PACKER_CSUM_EN
        w_csum_d = r_csum;
        if (w_fire && r_state != S_CSUM)
            w_csum_d = r_csum ^ r_tx_data;
`endif
        unique case (r_state)
            S_IDLE, S_END: begin
                w_req_ready = 1'b1;
                w_done      = (r_state == S_END);
                w_state_d   = S_IDLE;
                if (req_valid_i) begin
                    w_len_d      = w_len_cl;
                    w_addr_d     = req_addr_i;
                    w_write_d    = req_write_i;
                    w_rem_d      = w_len_cl;
                    w_tx_data_d  = req_write_i ? CMD_WRITE : CMD_READ;
                    w_tx_valid_d = 1'b1;
                    w_state_d    = S_CMD;
`ifdef DBG_CMD_PACKER_CSUM_EN
                    w_csum_d     = 8'h00;
`endif
                end
            end
            S_CMD: begin
                if (w_fire) begin
                    w_tx_data_d = r_len;
                    w_state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (w_fire) begin
                    w_tx_data_d = r_addr[31:24];
                    w_bidx_d    = 2'd0;
                    w_state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_fire) begin
                    w_bidx_d = w_bidx_inc;
                    if (r_bidx != 2'd3) begin
                        w_tx_data_d = w_addr_nb;
                    end else if (r_write && r_rem != 8'd0) begin
                        w_tx_valid_d = 1'b0;
                        w_state_d    = S_DWAIT;
                    end else begin
`ifdef DBG_CMD_PACKER_CSUM_EN
                        w_tx_data_d  = w_csum_d;
                        w_state_d    = S_CSUM;
`else
                        w_tx_valid_d = 1'b0;
                        w_state_d    = S_END;
`endif
                    end
                end
            end
            S_DWAIT: begin
                w_wdata_ready = 1'b1;
                if (wdata_valid_i) begin
                    w_word_d     = wdata_i;
                    w_bidx_d     = 2'd0;
                    w_tx_data_d  = wdata_i[7:0];
                    w_tx_valid_d = 1'b1;
                    w_state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fire) begin
                    w_rem_d  = r_rem - 8'd1;
                    w_bidx_d = w_bidx_inc;
                    // Last byte may sit mid-word; the upper bytes are dropped.
                    if (r_rem == 8'd1) begin
`ifdef DBG_CMD_PACKER_CSUM_EN
                        w_tx_data_d  = w_csum_d;
                        w_state_d    = S_CSUM;
`else
                        w_tx_valid_d = 1'b0;
                        w_state_d    = S_END;
`endif
                    end else if (r_bidx == 2'd3) begin
                        w_tx_valid_d = 1'b0;
                        w_state_d    = S_DWAIT;
                    end else begin
                        w_tx_data_d = w_word_nb;
                    end
                end
            end
`ifdef DBG_CMD_PACKER_CSUM_EN
            S_CSUM: begin
                if (w_fire) begin
                    w_tx_valid_d = 1'b0;
                    w_state_d    = S_END;
                end
            end
`endif
            default: begin
                w_tx_valid_d = 1'b0;
                w_state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_len      <= 8'h00;
            r_addr     <= 32'h0;
            r_write    <= 1'b0;
            r_rem      <= 8'h00;
            r_bidx     <= 2'd0;
            r_word     <= 32'h0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_len      <= w_len_d;
            r_addr     <= w_addr_d;
            r_write    <= w_write_d;
            r_rem      <= w_rem_d;
            r_bidx     <= w_bidx_d;
            r_word     <= w_word_d;
            r_tx_data  <= w_tx_data_d;
            r_tx_valid <= w_tx_valid_d;
        end
    end

`ifdef DBG_CMD_PACKER_CSUM_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_csum <= 8'h00;
        else
            r_csum <= w_csum_d;
    end
`endif

    assign req_ready_o   = w_req_ready;
    assign wdata_ready_o = w_wdata_ready;
    assign frame_done_o  = w_done;
    assign busy_o        = (r_state != S_IDLE);
    assign tx_data_o     = r_tx_data;
    assign tx_valid_o    = r_tx_valid;

endmodule

// File: tb/tb_dbg_cmd_packer.sv
// Bench for dbg_cmd_packer: vector table of frames plus reset-abort sequence.
// Expected byte streams are queued at request time and popped on each accept.
module tb_dbg_cmd_packer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [7:0]  req_len_i = 8'h0;
    logic        wdata_valid_i = 1'b0;
    logic [31:0] wdata_i = 32'h0;
    logic        wdata_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_accept_i = 1'b0;
    logic        busy_o;
    logic        frame_done_o;

    dbg_cmd_packer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_len_i     (req_len_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_i       (wdata_i),
        .wdata_ready_o (wdata_ready_o),
        .tx_data_o     (tx_data_o),
        .tx_valid_o    (tx_valid_o),
        .tx_accept_i   (tx_accept_i),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          pct;
        logic [7:0]  exp_lenb;
        int          exp_nbytes;
        int          exp_words;
    } vec_t;

    vec_t        vecs[8];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] wq[$];
    int          errors = 0;
    int          checks = 0;
    int          nxfer = 0;
    int          ndone = 0;
    int          nwtake = 0;
    int          nwready = 0;
    int          accept_pct = 100;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h0;
    bit          wtake = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word_k(input vec_t v, input int k);
        if (k == 0) return v.w0;
        if (k == 1) return v.w1;
        return v.w0 ^ (32'(k) * 32'h9E37_79B1);
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid_o), 32'd1);
                check("stall_data", 32'(tx_data_o), 32'(prev_data));
            end
            if (tx_valid_o && tx_accept_i) begin
                got_q.push_back(tx_data_o);
                nxfer++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h expected none", tx_data_o);
                end else begin
                    check("byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = tx_valid_o && !tx_accept_i;
            prev_data  = tx_data_o;
            if (frame_done_o) ndone++;
            if (wdata_ready_o) nwready++;
            wtake = wdata_valid_i && wdata_ready_o;
        end else begin
            prev_stall = 1'b0;
            wtake      = 1'b0;
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (wtake) begin
            if (wq.size() > 0) void'(wq.pop_front());
            nwtake++;
            wtake = 1'b0;
        end
        wdata_valid_i = (wq.size() != 0);
        wdata_i       = (wq.size() != 0) ? wq[0] : 32'h0;
    end

    always @(posedge clk_i) begin
        #1;
        tx_accept_i = ($urandom_range(0, 99) < accept_pct);
    end

    task automatic start_req(input vec_t v, output bit ok);
        logic [7:0]  L;
        logic [7:0]  cmd;
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] w;
        int          nw;
        ok  = 1'b0;
        L   = (v.len > 8'd252) ? 8'd252 : v.len;
        cmd = v.wr ? 8'h10 : 8'h11;
        got_q.delete();
        exp_q.push_back(cmd);
        exp_q.push_back(L);
        for (int i = 0; i < 4; i++) begin
            w = v.addr >> (8 * (3 - i));
            exp_q.push_back(w[7:0]);
        end
        if (v.wr) begin
            for (int i = 0; i < int'(L); i++) begin
                w = word_k(v, i / 4) >> (8 * (i % 4));
                exp_q.push_back(w[7:0]);
            end
        end
        cs = 8'h00;
        foreach (exp_q[i]) cs = cs ^ exp_q[i];
`ifdef DBG_CMD_PACKER_CSUM_EN
        exp_q.push_back(cs);
`endif
        nw = v.wr ? (int'(L) + 3) / 4 : 0;
        for (int k = 0; k < nw; k++) wq.push_back(word_k(v, k));
        accept_pct = v.pct;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b1;
        req_write_i = v.wr;
        req_addr_i  = v.addr;
        req_len_i   = v.len;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        if (!ok) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            return;
        end
        @(negedge clk_i);
        check("first_valid", 32'(tx_valid_o), 32'd1);
        check("first_cmd", 32'(tx_data_o), 32'(cmd));
        check("busy_hi", 32'(busy_o), 32'd1);
        check("req_ready_lo", 32'(req_ready_o), 32'd0);
        b = tx_data_o;
    endtask

    task automatic run_frame(input vec_t v);
        bit ok;
        bit done;
        int d0;
        int t0;
        int r0;
        int nb;
        d0 = ndone;
        t0 = nwtake;
        r0 = nwready;
        start_req(v, ok);
        if (!ok) return;
        done = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk_i);
            if (ndone != d0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check("frame_done_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (3) @(posedge clk_i);
        nb = v.exp_nbytes;
`ifdef DBG_CMD_PACKER_CSUM_EN
        nb++;
`endif
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("frame_bytes", 32'(got_q.size()), 32'(nb));
        if (got_q.size() > 1)
            check("len_byte", 32'(got_q[1]), 32'(v.exp_lenb));
        check("done_pulses", 32'(ndone - d0), 32'd1);
        check("words_taken", 32'(nwtake - t0), 32'(v.exp_words));
        check("wq_drained", 32'(wq.size()), 32'd0);
        if (!v.wr)
            check("rd_no_wready", 32'(nwready - r0), 32'd0);
        exp_q.delete();
        wq.delete();
    endtask

    initial begin
        bit ok;
        int x0;
        int d0;
        vec_t rv;

        vecs[0] = '{1'b1, 32'h0000_0000, 8'd4, 32'h0000_0100, 32'h0,
                    100, 8'd4, 10, 1};
        vecs[1] = '{1'b0, 32'hF000_0004, 8'd4, 32'h0, 32'h0,
                    100, 8'd4, 6, 0};
        vecs[2] = '{1'b1, 32'h0000_0040, 8'd6, 32'h4433_2211, 32'hAABB_6655,
                    100, 8'd6, 12, 2};
        vecs[3] = '{1'b1, 32'h1234_5678, 8'd0, 32'hDEAD_BEEF, 32'h0,
                    100, 8'd0, 6, 0};
        vecs[4] = '{1'b1, 32'hCAFE_0000, 8'd72, 32'h0102_0304, 32'h0506_0708,
                    30, 8'd72, 78, 18};
        vecs[5] = '{1'b1, 32'h8000_0000, 8'd255, 32'hA5A5_5A5A, 32'h1357_9BDF,
                    100, 8'd252, 258, 63};
        vecs[6] = '{1'b0, 32'h0000_FFFF, 8'd200, 32'h0, 32'h0,
                    50, 8'd200, 6, 0};
        vecs[7] = '{1'b1, 32'h00AB_CDEF, 8'd253, 32'h7777_0001, 32'h8888_0002,
                    60, 8'd252, 258, 63};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_wdata_ready", 32'(wdata_ready_o), 32'd0);
        check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("rst_tx_data", 32'(tx_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(frame_done_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        rv = '{1'b1, 32'h1122_3344, 8'd8, 32'h0403_0201, 32'h0807_0605,
               100, 8'd8, 14, 2};
        x0 = nxfer;
        start_req(rv, ok);
        if (ok) begin
            for (int c = 0; c < 200; c++) begin
                @(posedge clk_i);
                if (nxfer >= x0 + 3) break;
            end
            check("abort_progress", 32'(nxfer - x0 >= 3), 32'd1);
            #2;
            rst_i = 1'b0;
            #1;
            check("abort_tx_valid", 32'(tx_valid_o), 32'd0);
            check("abort_busy", 32'(busy_o), 32'd0);
            check("abort_req_ready", 32'(req_ready_o), 32'd1);
            exp_q.delete();
            wq.delete();
            d0 = ndone;
            repeat (3) @(posedge clk_i);
            #1;
            rst_i = 1'b1;
            repeat (4) @(posedge clk_i);
            check("abort_no_done", 32'(ndone - d0), 32'd0);
        end
        run_frame(vecs[0]);
        run_frame(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dbg_cmd_packer.md
Name: dbg_cmd_packer

Overview:
- Frame builder upstream of the debug-bridge TX byte FIFO and UART.
- Turns word-level host bus requests (write/read, address, length, data words) into the debug-bridge UART command byte stream.
- Stream format: CMD byte, LEN byte, 4 address bytes MSB first, then data bytes, each word LSB first.
- Replaces hand-built byte arrays with a synthesizable, back-pressured source for the FIFO push side.

Parameters:
- CMD_WRITE, 8'h10, command byte for write frames
- CMD_READ, 8'h11, command byte for read frames
- MAX_LEN, 252, largest accepted length in bytes; larger lengths are clamped

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- req_write_i  in  1  1 = write frame, 0 = read frame
- req_addr_i  in  32  target address
- req_len_i  in  8  payload length in bytes
- wdata_valid_i  in  1  write-data word valid
- wdata_i  in  32  write-data word
- wdata_ready_o  out  1  write-data word accepted when high with wdata_valid_i
- tx_data_o  out  8  byte to TX FIFO
- tx_valid_o  out  1  byte valid (FIFO push)
- tx_accept_i  in  1  FIFO accept
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse after last byte of frame accepted

Behaviour:
- Reset (rst_i low, async): state IDLE. Outputs reset to: req_ready_o=1, wdata_ready_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, frame_done_o=0.
- Internal registers:
  - cmd, len (clamped to MAX_LEN), addr.
  - rem: bytes remaining.
  - bidx: 2-bit byte index within the current word.
  - word: captured data word.
- Handshake:
  - A byte transfers on tx_valid_o && tx_accept_i.
  - tx_data_o and tx_valid_o are registered and must stay stable until accepted.
  - tx_valid_o never drops without acceptance, except on reset.
- States and transitions:
  - IDLE: req_ready_o=1. On req_valid_i, capture the request and go to CMD with tx_data_o=cmd, tx_valid_o=1. First byte appears 1 cycle after request acceptance.
  - CMD: on accept -> LEN with tx_data_o=len.
  - LEN: on accept -> ADDR, byte 0 = addr[31:24].
  - ADDR: sends addr[31:24], [23:16], [15:8], [7:0]. After the 4th accept: if write and len>0 go to DWAIT (tx_valid_o=0), otherwise go to END.
  - DWAIT: wdata_ready_o=1. On wdata_valid_i, capture the word, bidx=0, go to DATA with tx_data_o=wdata_i[7:0] on the next cycle.
  - DATA: emits word[8*bidx+7:8*bidx].
    - Each accept: rem--, bidx++.
    - rem reaches 0 -> END.
    - bidx wraps 3->0 with rem>0 -> DWAIT.
    - A partial last word (len not a multiple of 4) emits only its low rem bytes; the upper bytes are discarded.
  - END: frame_done_o=1 for one cycle, then back to IDLE. req_ready_o returns 1 on that same cycle.
- Frame lengths:
  - Write frame: 6 + len bytes; words consumed = ceil(len/4).
  - Read frame: 6 bytes; no data words are consumed.
  - len=0 write: header only, no data words consumed.
- Outputs by state:
  - busy_o=1 in every state except IDLE.
  - wdata_ready_o=1 only in DWAIT.
- Boundary conditions:
  - tx_accept_i held low stalls indefinitely with data stable.
  - wdata_valid_i outside DWAIT is ignored and not consumed.
  - req_valid_i while busy is not accepted.
  - req_len_i > MAX_LEN: clamped; the LEN byte shows the clamped value.
  - Reset mid-frame: immediate return to IDLE; the partial frame is abandoned and no frame_done_o pulse is generated.

Optional Feature:
- DBG_CMD_PACKER_CSUM_EN defined:
  - A CSUM state is inserted before END. It emits one extra byte: the XOR of all frame bytes from CMD through the last data byte.
  - The accumulator clears on request acceptance.
  - Frame length grows by 1.
- Undefined: no checksum logic; END follows the last data or address byte directly.

Test Plan:
- Write, addr 32'h0000_0000, len 4, word 32'h0000_0100 -> bytes 10,04,00,00,00,00,00,01,00,00; one wdata handshake; frame_done_o pulses once.
- Read, addr 32'hF000_0004, len 4 -> bytes 11,04,F0,00,00,04; wdata_ready_o never asserted.
- Write, len 6, words 32'h4433_2211 then 32'hAABB_6655 -> data bytes 11,22,33,44,55,66; AA and BB are never sent.
- Random tx_accept_i at 30% duty on a 72-byte write -> byte sequence identical to the no-stall case; tx_data_o stable whenever tx_valid_o && !tx_accept_i.
- Assert rst_i low after 3 bytes of a frame -> tx_valid_o=0 immediately, no frame_done_o pulse; the next request sends a complete fresh frame.
- With DBG_CMD_PACKER_CSUM_EN: write, addr 0, len 4, data 32'h0000_0001 -> extra final byte 8'h15 (10^04^01).
